// File: rtl/ifmap_loader.sv
// ifmap_loader: turns a raster-ordered ifmap pixel stream (valid/ready) into
// register-file writes at consecutive addresses, then kicks the toeplitz buffer
// router and waits for it to finish.
// Optional feature: define IFMAP_LOADER_CLEAR_EN to zero-fill the addresses
// above the loaded ifmap before the router is started.
module ifmap_loader #(
    parameter int  dataSize    = 8,
    parameter int  numRegister = 256,
    localparam int nAddress    = $clog2(numRegister)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [dataSize-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [dataSize-1:0] wr_data,
    output logic [nAddress-1:0] wr_addr,
    output logic                wr_en,
    input  logic [15:0]         cfg_ifmap_width,
    input  logic                ctrl_load,
    output logic                router_start,
    input  logic                router_done,
    output logic                flag_done,
    output logic                flag_err
);

    localparam int                  AW1       = nAddress + 1;
    localparam logic [nAddress:0]   NREG      = AW1'(numRegister);
    localparam logic [nAddress:0]   ONE_W     = AW1'(1);
    localparam logic [nAddress-1:0] ONE_A     = nAddress'(1);
    localparam logic [nAddress-1:0] LAST_ADDR = nAddress'(numRegister - 1);

`ifdef IFMAP_LOADER_CLEAR_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_KICK  = 3'd3,
        S_WAIT  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_KICK  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [nAddress-1:0]   cnt_q, cnt_d;
    logic [nAddress:0]     total_q, total_d;
    logic                  wr_en_q, wr_en_d;
    logic [nAddress-1:0]   wr_addr_q, wr_addr_d;
    logic [dataSize-1:0]   wr_data_q, wr_data_d;
    logic                  flag_done_q, flag_done_d;
    logic                  flag_err_q, flag_err_d;

    logic [31:0]           total_sq;
    logic                  beat;
    logic                  last_beat;

    // Pixel count is computed wide so an oversized width cannot alias into range.
    assign total_sq  = {16'd0, cfg_ifmap_width} * {16'd0, cfg_ifmap_width};
    assign beat      = (state_q == S_LOAD) && s_valid;
    assign last_beat = ({1'b0, cnt_q} == (total_q - ONE_W));

    assign s_ready      = (state_q == S_LOAD);
    assign router_start = (state_q == S_KICK);
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign flag_done    = flag_done_q;
    assign flag_err     = flag_err_q;

    // Next-state and registered-output decode for the load sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        flag_done_d = 1'b0;
        flag_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_load) begin
                    if ((cfg_ifmap_width < 16'd3) || (total_sq > 32'(numRegister))) begin
                        flag_err_d = 1'b1;
                    end else begin
                        total_d = total_sq[nAddress:0];
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = s_data;
                    cnt_d     = cnt_q + ONE_A;
                    if (last_beat) begin
`ifdef IFMAP_LOADER_CLEAR_EN
                        // A full register file leaves nothing stale to clear.
                        state_d = (total_q == NREG) ? S_DRAIN : S_CLEAR;
`else
                        state_d = S_DRAIN;
`endif
                    end
                end
            end
`ifdef IFMAP_LOADER_CLEAR_EN
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + ONE_A;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                state_d = S_KICK;
            end
            S_KICK: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (router_done) begin
                    flag_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any load in progress.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            total_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            flag_done_q <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            flag_done_q <= flag_done_d;
            flag_err_q  <= flag_err_d;
        end
    end

endmodule

// File: tb/tb_ifmap_loader.sv
// Bench for ifmap_loader: expected writes are queued as pixels are driven and
// popped as the loader emits them; control pulses are checked cycle by cycle.
module tb_ifmap_loader;

    logic        clk;
    logic        nrst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  wr_data;
    logic [7:0]  wr_addr;
    logic        wr_en;
    logic [15:0] cfg_ifmap_width;
    logic        ctrl_load;
    logic        router_start;
    logic        router_done;
    logic        flag_done;
    logic        flag_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb[$];

    ifmap_loader dut (
        .clk(clk),
        .nrst(nrst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .wr_data(wr_data),
        .wr_addr(wr_addr),
        .wr_en(wr_en),
        .cfg_ifmap_width(cfg_ifmap_width),
        .ctrl_load(ctrl_load),
        .router_start(router_start),
        .router_done(router_done),
        .flag_done(flag_done),
        .flag_err(flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({s_ready, wr_en, wr_addr, wr_data, router_start, flag_done, flag_err} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {s_ready, wr_en, wr_addr, wr_data, router_start, flag_done, flag_err});
        end
        nrst    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (s_ready !== 1'b0 || wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ignores_valid: got ready=%b wr_en=%b want 0 0", s_ready, wr_en);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_full_rate();
        int sent = 0, writes = 0, starts = 0, start_it = -1, first_it = -1, last_it = -1;
        logic [15:0] exp;
        cfg_ifmap_width = 16'd4;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_ready_after_load: got %b want 1", s_ready);
        end
        for (int it = 0; it < 24; it++) begin
            if (sent < 16) begin
                s_valid = 1'b1;
                s_data  = 8'(8'h10 + sent);
                sb.push_back({8'(sent), 8'(8'h10 + sent)});
                sent++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (first_it < 0) first_it = it;
                last_it = it;
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL full_write: unexpected write addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    exp = sb.pop_front();
                    if ({wr_addr, wr_data} !== exp) begin
                        n_err++;
                        $display("FAIL full_write: got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_addr, wr_data, exp[15:8], exp[7:0]);
                    end
                end
            end
            if (router_start === 1'b1) begin
                starts++;
                start_it = it;
            end
            if (it == 15) begin
                n_cmp++;
                if (s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_drain_ready: got %b want 0", s_ready);
                end
            end
        end
        n_cmp++;
        if (writes != 16 || first_it != 0 || last_it != 15) begin
            n_err++;
            $display("FAIL full_write_span: got %0d writes it %0d..%0d want 16 it 0..15", writes, first_it, last_it);
        end
        n_cmp++;
        if (starts != 1 || start_it != 16) begin
            n_err++;
            $display("FAIL full_router_start: got %0d pulses at it %0d want 1 at it 16", starts, start_it);
        end
        router_done = 1'b1;
        @(negedge clk);
        router_done = 1'b0;
        n_cmp++;
        if (flag_done !== 1'b1) begin
            n_err++;
            $display("FAIL full_flag_done: got %b want 1", flag_done);
        end
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_toggle();
        int sent = 0, writes = 0, starts = 0;
        logic prev_beat = 1'b0;
        logic [15:0] exp;
        cfg_ifmap_width = 16'd3;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        for (int it = 0; it < 26; it++) begin
            s_valid = (it % 2 == 0);
            s_data  = 8'(8'hA0 + it);
            prev_beat = s_valid && (sent < 9);
            if (prev_beat) begin
                sb.push_back({8'(sent), 8'(8'hA0 + it)});
                sent++;
            end
            @(negedge clk);
            if (wr_en !== prev_beat) begin
                n_cmp++;
                n_err++;
                $display("FAIL toggle_wr_en: it %0d got %b want %b", it, wr_en, prev_beat);
            end else if (wr_en === 1'b1) begin
                writes++;
                n_cmp++;
                exp = sb.pop_front();
                if ({wr_addr, wr_data} !== exp) begin
                    n_err++;
                    $display("FAIL toggle_write: got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr, wr_data, exp[15:8], exp[7:0]);
                end
            end
            if (router_start === 1'b1) begin
                starts++;
                n_cmp++;
                if (it != 17) begin
                    n_err++;
                    $display("FAIL toggle_start_time: got it %0d want it 17", it);
                end
            end
        end
        s_valid = 1'b0;
        n_cmp++;
        if (writes != 9 || starts != 1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL toggle_counts: got writes=%0d starts=%0d left=%0d want 9 1 0", writes, starts, sb.size());
        end
        router_done = 1'b1;
        @(negedge clk);
        router_done = 1'b0;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reject();
        logic [15:0] wl [3] = '{16'd17, 16'd2, 16'd0};
        for (int k = 0; k < 3; k++) begin
            cfg_ifmap_width = wl[k];
            ctrl_load = 1'b1;
            s_valid   = 1'b1;
            @(negedge clk);
            ctrl_load = 1'b0;
            n_cmp++;
            if (flag_err !== 1'b1 || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL reject_err_w%0d: got err=%b ready=%b want 1 0", wl[k], flag_err, s_ready);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                n_cmp++;
                if (flag_err !== 1'b0 || s_ready !== 1'b0 || wr_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL reject_quiet_w%0d: got err=%b ready=%b wr_en=%b want 0 0 0",
                             wl[k], flag_err, s_ready, wr_en);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_ignored_load();
        int sent = 0, writes = 0, starts = 0, dones = 0, done_it = -1, late_ready = 0;
        logic [15:0] exp;
        cfg_ifmap_width = 16'd3;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        for (int it = 0; it < 24; it++) begin
            ctrl_load   = (it == 2 || it == 3 || (it >= 11 && it <= 14));
            router_done = (it == 15);
            if (sent < 9) begin
                s_valid = 1'b1;
                s_data  = 8'(8'h30 + sent);
                sb.push_back({8'(sent), 8'(8'h30 + sent)});
                sent++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (wr_en === 1'b1) begin
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL ign_write: unexpected write addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    exp = sb.pop_front();
                    if ({wr_addr, wr_data} !== exp) begin
                        n_err++;
                        $display("FAIL ign_write: got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_addr, wr_data, exp[15:8], exp[7:0]);
                    end
                end
            end
            if (router_start === 1'b1) starts++;
            if (flag_done === 1'b1) begin
                dones++;
                done_it = it;
            end
            if (it >= 9 && s_ready === 1'b1) late_ready++;
        end
        ctrl_load   = 1'b0;
        router_done = 1'b0;
        n_cmp++;
        if (writes != 9 || starts != 1) begin
            n_err++;
            $display("FAIL ign_counts: got writes=%0d starts=%0d want 9 1", writes, starts);
        end
        n_cmp++;
        if (dones != 1 || done_it != 15) begin
            n_err++;
            $display("FAIL ign_flag_done: got %0d pulses at it %0d want 1 at it 15", dones, done_it);
        end
        n_cmp++;
        if (late_ready != 0) begin
            n_err++;
            $display("FAIL ign_no_restart: got %0d ready cycles want 0", late_ready);
        end
        sb.delete();
    endtask

    task automatic test_reset_midload();
        int sent = 0, writes = 0;
        logic [15:0] exp;
        cfg_ifmap_width = 16'd4;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        for (int it = 0; it < 5; it++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h50 + sent);
            sent++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, wr_en, wr_addr, wr_data, router_start, flag_done, flag_err} !== 21'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b want all zero",
                     {s_ready, wr_en, wr_addr, wr_data, router_start, flag_done, flag_err});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        sent = 0;
        for (int it = 0; it < 20; it++) begin
            if (sent < 16) begin
                s_valid = 1'b1;
                s_data  = 8'(8'h60 + sent);
                sb.push_back({8'(sent), 8'(8'h60 + sent)});
                sent++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (wr_en === 1'b1) begin
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL restart_write: unexpected write addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    exp = sb.pop_front();
                    if ({wr_addr, wr_data} !== exp) begin
                        n_err++;
                        $display("FAIL restart_write: got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_addr, wr_data, exp[15:8], exp[7:0]);
                    end
                end
            end
        end
        n_cmp++;
        if (writes != 16) begin
            n_err++;
            $display("FAIL restart_count: got %0d writes want 16", writes);
        end
        router_done = 1'b1;
        @(negedge clk);
        router_done = 1'b0;
        @(negedge clk);
        sb.delete();
    endtask

`ifdef IFMAP_LOADER_CLEAR_EN
    task automatic test_clear();
        int sent = 0, writes = 0, starts = 0, start_it = -1;
        logic [15:0] exp;
        cfg_ifmap_width = 16'd15;
        ctrl_load = 1'b1;
        @(negedge clk);
        ctrl_load = 1'b0;
        for (int it = 0; it < 270; it++) begin
            if (sent < 225) begin
                s_valid = 1'b1;
                s_data  = 8'(sent) ^ 8'hA5;
                sb.push_back({8'(sent), 8'(sent) ^ 8'hA5});
                sent++;
                if (sent == 225) begin
                    for (int a = 225; a < 256; a++) sb.push_back({8'(a), 8'h00});
                end
            end else begin
                s_valid = 1'b1;
                s_data  = 8'hFF;
            end
            @(negedge clk);
            if (wr_en === 1'b1) begin
                writes++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL clear_write: unexpected write addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    exp = sb.pop_front();
                    if ({wr_addr, wr_data} !== exp) begin
                        n_err++;
                        $display("FAIL clear_write: got addr=%0d data=%h want addr=%0d data=%h",
                                 wr_addr, wr_data, exp[15:8], exp[7:0]);
                    end
                end
            end
            if (router_start === 1'b1) begin
                starts++;
                start_it = it;
            end
        end
        s_valid = 1'b0;
        n_cmp++;
        if (writes != 256 || starts != 1 || start_it != 256) begin
            n_err++;
            $display("FAIL clear_counts: got writes=%0d starts=%0d at it %0d want 256 1 at it 256",
                     writes, starts, start_it);
        end
        router_done = 1'b1;
        @(negedge clk);
        router_done = 1'b0;
        @(negedge clk);
        sb.delete();
    endtask
`endif

    initial begin
        nrst            = 1'b0;
        s_data          = 8'h00;
        s_valid         = 1'b0;
        cfg_ifmap_width = 16'd0;
        ctrl_load       = 1'b0;
        router_done     = 1'b0;
        test_reset();
        test_full_rate();
        test_toggle();
        test_reject();
        test_ignored_load();
        test_reset_midload();
`ifdef IFMAP_LOADER_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
